// File: rtl/sram_req_if.sv
// sram_req_if: request/response handshake bundle plus the 1RW SRAM port of the adapter
interface sram_req_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front-end for a 1RW SRAM with a credit-limited in-order read response FIFO
module sram_req_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  sram_req_if.slave   bus
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);
  logic [DATA_WIDTH-1:0] storage [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  rd_inflight, acc, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST_C ? '0 : p + 1'b1;
  endfunction
  // Credits cover the read still in the SRAM pipeline, so its data always has a slot.
  assign occ            = {1'b0, count} + {{CW{1'b0}}, rd_inflight};
  assign bus.req_ready  = rst_ni && (occ < DEPTH_C);
  assign acc            = bus.req_valid && bus.req_ready;
  assign bus.sram_we    = acc && bus.req_we;
  assign bus.sram_addr  = bus.req_addr;
  assign bus.sram_wdata = bus.req_wdata;
  assign push           = rd_inflight;
  assign bus.rsp_valid  = count != '0;
  assign bus.rsp_rdata  = storage[rd_ptr];
  assign pop            = bus.rsp_valid && bus.rsp_ready;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) storage[i] <= '0;
    end else begin
      rd_inflight <= acc && !bus.req_we;
      if (push) begin
        storage[wr_ptr] <= bus.sram_rdata;
        wr_ptr          <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
    end
  end
  count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: directed table, corner sequences and random traffic against a queue-based reference model
module tb_sram_req_adapter;
  localparam int DEPTH = 3;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;
  sram_req_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
  sram_req_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RSP_DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );
  logic [31:0] mem [256];
  always @(posedge clk_i) begin
    if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
    bus.sram_rdata <= mem[bus.sram_addr];
  end
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;
  typedef struct {
    logic        v, we;
    logic [7:0]  a;
    logic [31:0] d;
    logic        rr, er, ev;
    logic [31:0] ed;
  } vec_t;
  rsp_t        q[$];
  logic [31:0] ref_mem [256];
  int          total = 0, bad = 0, cyc = 0, n_pop = 0, first_pop = -1, last_pop = -1;
  logic        m_acc, m_pop, m_we;
  logic [7:0]  m_a;
  logic [31:0] m_d;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d, input logic rr);
    logic er, ev;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #1;
    er = rst_n && (q.size() < DEPTH);
    ev = rst_n && (q.size() > 0) && (cyc - q[0].cyc >= 2);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    if (ev) chk("rsp_rdata", bus.rsp_rdata, q[0].data);
    chk("sram_we", 32'(bus.sram_we), 32'(v && er && we));
    m_acc = v && er;
    m_pop = ev && rr;
    m_we  = we;
    m_a   = a;
    m_d   = d;
  endtask
  task automatic advance();
    @(posedge clk_i);
    if (rst_n) begin
      if (m_pop) begin
        void'(q.pop_front());
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (m_acc && m_we) ref_mem[m_a] = m_d;
      if (m_acc && !m_we) q.push_back('{ref_mem[m_a], cyc});
    end
    cyc++;
    @(negedge clk_i);
  endtask
  task automatic cycle(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d, input logic rr);
    drive(v, we, a, d, rr);
    advance();
  endtask
  vec_t tbl[$];
  initial begin
    int p0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    // {v, we, addr, wdata, rsp_ready, exp ready, exp valid, exp rdata}
    tbl = '{
      '{1, 1, 8'h10, 32'hDEADBEEF, 1, 1, 0, 0},
      '{1, 0, 8'h10, 0,            1, 1, 0, 0},
      '{0, 0, 8'h00, 0,            1, 1, 0, 0},
      '{0, 0, 8'h00, 0,            1, 1, 1, 32'hDEADBEEF},
      '{0, 0, 8'h00, 0,            1, 1, 0, 0},
      '{1, 1, 8'h20, 32'h5,        1, 1, 0, 0},
      '{1, 0, 8'h20, 0,            1, 1, 0, 0},
      '{0, 0, 8'h00, 0,            1, 1, 0, 0},
      '{0, 0, 8'h00, 0,            1, 1, 1, 32'h5},
      '{0, 0, 8'h00, 0,            1, 1, 0, 0},
      '{1, 0, 8'h10, 0,            0, 1, 0, 0},
      '{1, 0, 8'h20, 0,            0, 1, 0, 0},
      '{1, 0, 8'h10, 0,            0, 1, 1, 32'hDEADBEEF},
      '{1, 0, 8'h20, 0,            0, 0, 1, 32'hDEADBEEF},
      '{1, 0, 8'h10, 0,            0, 0, 1, 32'hDEADBEEF},
      '{0, 0, 8'h00, 0,            1, 0, 1, 32'hDEADBEEF},
      '{0, 0, 8'h00, 0,            1, 1, 1, 32'h5},
      '{0, 0, 8'h00, 0,            1, 1, 1, 32'hDEADBEEF},
      '{0, 0, 8'h00, 0,            1, 1, 0, 0}
    };
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    cycle(1, 1, 8'h33, 32'hBAD, 1);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_rdata", i), bus.rsp_rdata, tbl[i].ed);
      advance();
    end
    for (int i = 0; i < 8; i++) cycle(1, 1, 8'(i), 32'(i * 3), 1);
    p0 = n_pop;
    first_pop = -1;
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'(i), 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("b2b_count", 32'(n_pop - p0), 8);
    chk("b2b_span", 32'(last_pop - first_pop), 7);
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(i), 0, 0);
    drive(1, 1, 8'h05, 32'hBAD0BAD0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_rdata", bus.rsp_rdata, 0);
    chk("mid_rst_sram_we", 32'(bus.sram_we), 0);
    q.delete();
    m_acc = 1'b0;
    m_pop = 1'b0;
    advance();
    cycle(1, 1, 8'h05, 32'hBAD0BAD0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 8'h05, 0, 1);
    cycle(1, 0, 8'h10, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("post_rst_rd5", bus.rsp_rdata, 32'd15);
    advance();
    drive(0, 0, 0, 0, 1);
    chk("post_rst_rd10", bus.rsp_rdata, 32'hDEADBEEF);
    advance();
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 8'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 99) < 60);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("drain_valid", 32'(bus.rsp_valid), 0);
    advance();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
